div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_if.sv | 24 ++
 rtl/div_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle for the sequential 32/16 divider.
// The requester (master) drives start and the operands; the divider (slave)
// returns busy/done status together with quotient, remainder and the
// divide-by-zero flag.
interface div_seq_if;
    logic        start;
    logic [31:0] P;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Q;
    logic [15:0] R;
    logic        dz;

    modport master (
        output start, P, B,
        input  busy, done, Q, R, dz
    );

    modport slave (
        input  start, P, B,
        output busy, done, Q, R, dz
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: unsigned 32-bit / 16-bit restoring divider, one quotient bit per
// clock, 32 steps per operation. Three-state control (IDLE, RUN, DONE).
// Optional build macro DIV_ZERO_DETECT_EN: a zero divisor skips RUN, reports
// dz=1 and returns Q=all-ones, R=P[15:0] one cycle after the start.
// Without the macro a zero divisor runs the normal 32 steps, which naturally
// produce the same Q/R, and dz stays 0.
module div_seq (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_fast_dz;

    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom, so one register serves both roles during RUN.
    logic [31:0] r_dq;
    logic [15:0] r_div;
    logic [16:0] r_rem;
    logic [4:0]  r_cnt;

    logic [31:0] r_q;
    logic [15:0] r_r;
    logic        r_dz;

    logic [17:0] w_step;
    logic [16:0] w_rem_nxt;
    logic        w_qbit;
    logic        w_last;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. Returns
    // {new remainder, quotient bit}.
    function automatic logic [17:0] restore_step(
        input logic [16:0] rem,
        input logic        din,
        input logic [15:0] dvs
    );
        logic [16:0] sh;
        sh = {rem[15:0], din};
        if (sh >= {1'b0, dvs})
            return {sh - {1'b0, dvs}, 1'b1};
        else
            return {sh, 1'b0};
    endfunction

    assign w_step    = restore_step(r_rem, r_dq[31], r_div);
    assign w_rem_nxt = w_step[17:1];
    assign w_qbit    = w_step[0];
    assign w_last    = (r_state == S_RUN) && (r_cnt == 5'd31);

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fast_dz   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                    if (bus.B == 16'd0) begin
                        w_fast_dz   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (r_cnt == 5'd31)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Step counter: cleared on acceptance, advances once per RUN step.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= 5'd0;
        else if (w_accept)
            r_cnt <= 5'd0;
        else if (r_state == S_RUN)
            r_cnt <= r_cnt + 5'd1;
    end

    // Working datapath: operand capture and iterative shift/subtract.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dq  <= bus.P;
            r_div <= bus.B;
            r_rem <= 17'd0;
        end else if (r_state == S_RUN) begin
            r_dq  <= {r_dq[30:0], w_qbit};
            r_rem <= w_rem_nxt;
        end
    end

    // Visible results: written only when an operation completes, so they
    // hold steady through IDLE and the whole of the next RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q  <= 32'd0;
            r_r  <= 16'd0;
            r_dz <= 1'b0;
        end else if (w_fast_dz) begin
            r_q  <= 32'hFFFF_FFFF;
            r_r  <= bus.P[15:0];
            r_dz <= 1'b1;
        end else if (w_last) begin
            r_q  <= {r_dq[30:0], w_qbit};
            r_r  <= w_rem_nxt[15:0];
            r_dz <= 1'b0;
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.Q    = r_q;
    assign bus.R    = r_r;
    assign bus.dz   = r_dz;

endmodule
